cpu0_console_io: RTL and testbench
==================================

CPU0_CONSOLE_IO -- requirements
Module: cpu0_console_io

Interface
REQ-001 The module SHALL have parameter IOADDR, default 'h7000, the byte address of the data port; the status port is at IOADDR+4.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 16, the character FIFO depth in bytes (power of two, at least 4).
REQ-003 The module SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The module SHALL have port en, input, 1 bit, the CPU bus access enable.
REQ-006 The module SHALL have port rw, input, 1 bit, the access direction: 1 = read, 0 = write.
REQ-007 The module SHALL have port m_size, input, 2 bits, the access width: 00 byte, 01 16-bit, 10 24-bit, 11 32-bit.
REQ-008 The module SHALL have port abus, input, 32 bits, the byte address.
REQ-009 The module SHALL have port dbus_in, input, 32 bits, the write data.
REQ-010 The module SHALL have port dbus_out, output, 32 bits, the read data; it is Z when not selected.
REQ-011 The module SHALL have port tx_valid, output, 1 bit, asserted while a character is offered.
REQ-012 The module SHALL have port tx_data, output, 8 bits, the offered character.
REQ-013 The module SHALL have port tx_ready, input, 1 bit, the sink's acceptance signal.

Function
REQ-014 Access SHALL be accepted only on a clock edge where en=1 and the registered previous en (en_d) is 0, so that exactly one acceptance occurs per CPU access.
REQ-015 A write (rw=0) to abus==IOADDR SHALL form a byte list from dbus_in, least-significant byte first, of 1/2/3/4 bytes for m_size 00/01/10/11.
REQ-016 For widths above one byte, the byte list SHALL be truncated at the first 8'h00 byte; a byte write pushes any value, including 00.
REQ-017 All bytes in the list SHALL be pushed into the FIFO in the accept cycle, in list order.
REQ-018 If the list length exceeds the free space at that edge, evaluated before any same-cycle pop, no byte SHALL be pushed and the overflow flag SHALL be set; the overflow flag is sticky.
REQ-019 A 32-bit write whose low byte is 00 SHALL push nothing and SHALL NOT set overflow.
REQ-020 Writes to IOADDR+4 and to any other address SHALL be ignored.
REQ-021 When en=1, rw=1 and abus==IOADDR+4, dbus_out SHALL present status combinationally: [7:0] count, [8] empty, [9] full, [10] overflow, other bits 0.
REQ-022 When en=1, rw=1 and abus==IOADDR, dbus_out SHALL be 32'h0; otherwise dbus_out SHALL be Z.
REQ-023 An accepted status read SHALL clear overflow at that edge; if a set condition occurs on the same edge, set wins.
REQ-024 tx_valid SHALL equal the FIFO not-empty condition, and tx_data SHALL equal the head entry, registered.
REQ-025 A pop SHALL occur on an edge where tx_valid=1 and tx_ready=1.
REQ-026 tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-027 First-write latency SHALL be one cycle: the byte is accepted at edge N and tx_valid=1 after edge N.
REQ-028 A simultaneous push and pop SHALL both take effect, with count = count + n - 1.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full means count == FIFO_DEPTH.

Reset
REQ-030 On reset=1 at a clock edge, the FIFO SHALL be flushed (pointers and count 0), overflow and en_d SHALL be 0, tx_valid SHALL be 0 and tx_data SHALL be 8'h00.
REQ-031 An access coincident with reset SHALL be discarded.
REQ-032 Reset mid-stream SHALL drop all pending characters with no partial output.

Configuration
REQ-033 With macro CONSOLE_ECHO_EN defined, each pop SHALL also $write the popped character to the simulator console as %c; without the macro there is no console output and the logic is otherwise identical.

Verification
REQ-034 The bench SHALL cover: byte write 8'h41 to 'h7000 with tx_ready=1 -> tx_valid high for exactly one cycle, tx_data=8'h41, count returns to 0.
REQ-035 The bench SHALL cover: 32-bit write 32'h00434241 with tx_ready=1 -> tx_data sequence 41, 42, 43, then tx_valid=0.
REQ-036 The bench SHALL cover: tx_ready=0 and 17 byte writes, DEPTH 16 -> status read returns full=1, overflow=1, count=16; the next status read returns overflow=0.
REQ-037 The bench SHALL cover: count=14 and a 32-bit write 32'h44434241 -> nothing pushed, overflow=1, count stays 14.
REQ-038 The bench SHALL cover: en held high for 3 cycles with a byte write -> exactly one byte pushed.
REQ-039 The bench SHALL cover: 5 bytes queued then reset pulse -> tx_valid=0 and count=0 the next cycle; a following write of 8'h5A emerges first.

Source files
------------

// File: rtl/cpu0_console_io.sv
// Memory-mapped console output: CPU byte/word writes feed a character FIFO drained over a valid/ready port.
// Define CONSOLE_ECHO_EN to also print each popped character to the simulator console.
module cpu0_console_io #(
  parameter logic [31:0] IOADDR     = 32'h7000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [31:0]       STATADDR = IOADDR + 32'd4;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             en_prev_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q, tx_data_d;

  logic [7:0]       wbyte [4];
  logic [2:0]       nbytes;
  logic [2:0]       list_len;
  logic             trunc;
  logic [CNT_W-1:0] free_space;
  logic             accept, wr_sel, st_sel, push, pop, ovf_set;
  logic [7:0]       head;
  logic [31:0]      status;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign wbyte[gi] = dbus_in[8*gi +: 8];
    end
  endgenerate

  // Multi-byte writes stop at the first NUL; a single-byte write carries any value.
  always_comb begin
    nbytes   = {1'b0, m_size} + 3'd1;
    list_len = 3'd0;
    trunc    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes && !trunc) begin
        if (m_size != 2'b00 && wbyte[k] == 8'h00) trunc = 1'b1;
        else list_len = list_len + 3'd1;
      end
    end
  end

  assign accept     = en & ~en_prev_q;
  assign wr_sel     = accept & ~rw & (abus == IOADDR);
  assign st_sel     = accept & rw & (abus == STATADDR);
  assign free_space = DEPTH_C - count_q;
  assign push       = wr_sel && (list_len != 3'd0) && (CNT_W'(list_len) <= free_space);
  assign ovf_set    = wr_sel && (CNT_W'(list_len) > free_space);
  assign pop        = tx_valid_q & tx_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PTR_W'(list_len) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (push ? CNT_W'(list_len) : CNT_W'(0)) - CNT_W'(pop);
    ovf_d    = ovf_set | (ovf_q & ~st_sel);
    // The new head may be a byte being written on this same edge.
    head = mem_q[rd_ptr_d];
    for (int k = 0; k < 4; k++) begin
      if (push && 3'(k) < list_len && (wr_ptr_q + PTR_W'(k)) == rd_ptr_d) head = wbyte[k];
    end
    tx_data_d = (count_d != '0) ? head : tx_data_q;
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < list_len) mem_q[wr_ptr_q + PTR_W'(k)] <= wbyte[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      en_prev_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      en_prev_q  <= en;
      tx_valid_q <= (count_d != '0);
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef CONSOLE_ECHO_EN
  always_ff @(posedge clock) begin
    if (!reset && pop) $write("%c", tx_data_q);
  end
`endif

  assign status   = {21'd0, ovf_q, (count_q == DEPTH_C), (count_q == '0), 8'(count_q)};
  assign dbus_out = (en && rw && abus == STATADDR) ? status :
                    (en && rw && abus == IOADDR)   ? 32'h0  : 32'bz;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_cpu0_console_io.sv
// Self-checking bench for cpu0_console_io: queue-based reference model plus directed scenarios.
module tb_cpu0_console_io;

  localparam logic [31:0] IOADDR   = 32'h7000;
  localparam logic [31:0] STATADDR = 32'h7004;
  localparam int          DEPTH    = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, rw = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic [31:0] abus = 32'h0, dbus_in = 32'h0;
  logic [31:0] dbus_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  cpu0_console_io #(.IOADDR(IOADDR), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .m_size(m_size),
    .abus(abus), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue, a sticky flag and the previous enable.
  logic [7:0] mq[$];
  logic [7:0] lst[$];
  bit         m_ovf = 0, m_enp = 0, live = 0;
  bit         m_acc, m_pop;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_ovf = 0;
      m_enp = 0;
      live  = 1;
    end else begin
      m_acc = en && !m_enp;
      m_pop = (mq.size() != 0) && tx_ready;
      lst.delete();
      if (m_acc && rw && abus == STATADDR) m_ovf = 0;
      if (m_acc && !rw && abus == IOADDR) begin
        for (int k = 0; k <= int'(m_size); k++) begin
          if (m_size != 2'b00 && dbus_in[8*k +: 8] == 8'h00) break;
          lst.push_back(dbus_in[8*k +: 8]);
        end
        if (lst.size() > DEPTH - mq.size()) begin
          m_ovf = 1;
          lst.delete();
        end
      end
      if (m_pop) void'(mq.pop_front());
      foreach (lst[k]) mq.push_back(lst[k]);
      m_enp = en;
    end
  end

  always @(negedge clock) begin
    if (live) begin
      check("tx_valid", {31'd0, tx_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, mq[0]});
    end
  end

  task automatic access(input logic r, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input bit gap);
    en = 1'b1; rw = r; m_size = sz; abus = a; dbus_in = d;
    repeat (hold) @(negedge clock);
    en = 1'b0;
    if (gap) @(negedge clock);
  endtask

  task automatic status_read(input string name, input logic [31:0] exp);
    en = 1'b1; rw = 1'b1; abus = STATADDR;
    #1;
    check(name, dbus_out, exp);
    @(negedge clock);
    en = 1'b0;
    @(negedge clock);
  endtask

  logic [7:0] got[$];
  task automatic watch(input int n, output int cnt);
    cnt = 0;
    got.delete();
    for (int i = 0; i < n; i++) begin
      if (tx_valid && tx_ready) begin
        cnt++;
        got.push_back(tx_data);
      end
      @(negedge clock);
    end
  endtask

  int c;

  initial begin
    repeat (3) @(negedge clock);
    check("reset_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_data", {24'd0, tx_data}, 32'h00);
    reset = 1'b0;
    @(negedge clock);
    status_read("reset_status", 32'h0000_0100);

    // Single byte passes through in exactly one valid cycle.
    tx_ready = 1'b1;
    access(1'b0, 2'b00, IOADDR, 32'h0000_0041, 1, 0);
    watch(4, c);
    check("byte_cycles", c, 1);
    check("byte_val", {24'd0, got[0]}, 32'h41);
    status_read("byte_cnt0", 32'h0000_0100);

    access(1'b0, 2'b11, IOADDR, 32'h0043_4241, 1, 0);
    watch(6, c);
    check("w32_cnt", c, 3);
    check("w32_b0", {24'd0, got[0]}, 32'h41);
    check("w32_b1", {24'd0, got[1]}, 32'h42);
    check("w32_b2", {24'd0, got[2]}, 32'h43);

    // Fill past capacity with the sink stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) access(1'b0, 2'b00, IOADDR, 32'h30 + i, 1, 1);
    status_read("full_ovf", 32'h0000_0610);
    status_read("ovf_clear", 32'h0000_0210);

    tx_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    tx_ready = 1'b0;
    status_read("cnt14", 32'h0000_000E);
    access(1'b0, 2'b11, IOADDR, 32'h4443_4241, 1, 1);
    status_read("ovf_cnt14", 32'h0000_040E);
    tx_ready = 1'b1;
    watch(20, c);
    check("drain_cnt", c, 14);
    check("drain_first", {24'd0, got[0]}, 32'h32);
    check("drain_last", {24'd0, got[13]}, 32'h3F);

    // Held enable is one access.
    tx_ready = 1'b0;
    access(1'b0, 2'b00, IOADDR, 32'h55, 3, 1);
    status_read("hold_en", 32'h0000_0001);
    tx_ready = 1'b1;
    watch(4, c);
    check("hold_pop", c, 1);

    tx_ready = 1'b0;
    access(1'b0, 2'b10, IOADDR, 32'h0000_4241, 1, 1);
    status_read("w24_trunc", 32'h0000_0002);
    access(1'b0, 2'b00, STATADDR, 32'h0000_0041, 1, 1);
    access(1'b0, 2'b00, 32'h7008, 32'h0000_0041, 1, 1);
    access(1'b0, 2'b01, IOADDR, 32'h0000_4100, 1, 1);
    status_read("ignored", 32'h0000_0002);
    access(1'b0, 2'b00, IOADDR, 32'h0000_0000, 1, 1);
    status_read("nul_byte", 32'h0000_0003);
    en = 1'b1; rw = 1'b1; abus = IOADDR;
    #1;
    check("data_read", dbus_out, 32'h0);
    @(negedge clock);
    en = 1'b0;
    @(negedge clock);
    tx_ready = 1'b1;
    watch(8, c);
    check("mix_cnt", c, 3);
    check("mix_b0", {24'd0, got[0]}, 32'h41);
    check("mix_b1", {24'd0, got[1]}, 32'h42);
    check("mix_b2", {24'd0, got[2]}, 32'h00);

    // Reset mid-stream, with a write coincident with reset.
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) access(1'b0, 2'b00, IOADDR, 32'h61 + i, 1, 1);
    status_read("five", 32'h0000_0005);
    reset = 1'b1; en = 1'b1; rw = 1'b0; abus = IOADDR; m_size = 2'b00; dbus_in = 32'h77;
    @(negedge clock);
    reset = 1'b0; en = 1'b0;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    status_read("rst_cnt", 32'h0000_0100);
    tx_ready = 1'b1;
    access(1'b0, 2'b00, IOADDR, 32'h5A, 1, 0);
    watch(4, c);
    check("post_rst_cnt", c, 1);
    check("post_rst_val", {24'd0, got[0]}, 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
